time_set_ctrl: RTL and testbench

- Owns the six BCD time digits (sec0..hour1) that feed the 7-segment scan driver.
- RUN state: counts time from a 1 Hz enable pulse.
- Set states: sequences a manual time-setting mode driven by two pre-debounced single-cycle button pulses.
- In set states, blinks the selected field by substituting code 4'hF on its digits; the scan driver renders any code above 9 as all segments off.

---
 rtl/time_set_ctrl.sv | 170 +++++++++++++++++
 tb/tb_time_set_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: owns the six BCD clock digits, counts time in RUN and
// sequences manual hour/min/sec setting with blinking of the edited field.
// Ports:
//   clk, rst (async, active low)
//   tick_1hz, blink_tick, btn_mode, btn_inc : one-clk pulses
//   sec0..hour1 : registered BCD digits (4'hF = blanked)
//   mode        : 00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
module time_set_ctrl #(
   parameter int HOUR_MAX  = 23,
   parameter int BLINK_DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       blink_tick,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [3:0] sec0,
   output logic [3:0] sec1,
   output logic [3:0] min0,
   output logic [3:0] min1,
   output logic [3:0] hour0,
   output logic [3:0] hour1,
   output logic [1:0] mode
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      SET_HOUR = 2'b01,
      SET_MIN  = 2'b10,
      SET_SEC  = 2'b11
   } state_t;

   localparam logic [3:0] HM1  = 4'(HOUR_MAX / 10);
   localparam logic [3:0] HM0  = 4'(HOUR_MAX % 10);
   localparam logic [7:0] BDIV = 8'(BLINK_DIV);
   localparam logic [3:0] BLK  = 4'hF;

   state_t     state_q, state_d;
   logic [3:0] s0_q, s1_q, m0_q, m1_q, h0_q, h1_q;
   logic [3:0] s0_d, s1_d, m0_d, m1_d, h0_d, h1_d;
   logic [7:0] bcnt_q, bcnt_d;
   logic       phase_q, phase_d;
   logic       inc_s, inc_m, inc_h;
   logic       s_top, m_top, h_top;
   logic       edit, blank;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= RUN;
      else      state_q <= state_d;
   end

   // next state: btn_mode walks the ring
   always_comb begin
      state_d = state_q;
      if (btn_mode) state_d = state_t'(state_q + 2'd1);
   end

   assign mode = state_q;

   // time / blink datapath
   always_comb begin
      s0_d = s0_q;
      s1_d = s1_q;
      m0_d = m0_q;
      m1_d = m1_q;
      h0_d = h0_q;
      h1_d = h1_q;
      bcnt_d = bcnt_q;
      phase_d = phase_q;
      inc_s = 1'b0;
      inc_m = 1'b0;
      inc_h = 1'b0;
      s_top = (s1_q == 4'd5) && (s0_q == 4'd9);
      m_top = (m1_q == 4'd5) && (m0_q == 4'd9);
      h_top = (h1_q == HM1) && (h0_q == HM0);
      // mode advance swallows a coincident increment
      edit = (state_q != RUN) && btn_inc && !btn_mode;

      unique case (state_q)
         RUN: begin
            inc_s = tick_1hz;
            inc_m = tick_1hz && s_top;
            inc_h = tick_1hz && s_top && m_top;
         end
         SET_HOUR: inc_h = edit;
         SET_MIN:  inc_m = edit;
         SET_SEC:  inc_s = edit;
      endcase

      if (inc_s) begin
         if (s0_q == 4'd9) begin
            s0_d = 4'd0;
            s1_d = (s1_q == 4'd5) ? 4'd0 : s1_q + 4'd1;
         end else begin
            s0_d = s0_q + 4'd1;
         end
      end
      if (inc_m) begin
         if (m0_q == 4'd9) begin
            m0_d = 4'd0;
            m1_d = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
         end else begin
            m0_d = m0_q + 4'd1;
         end
      end
      if (inc_h) begin
         if (h_top) begin
            h0_d = 4'd0;
            h1_d = 4'd0;
         end else if (h0_q == 4'd9) begin
            h0_d = 4'd0;
            h1_d = h1_q + 4'd1;
         end else begin
            h0_d = h0_q + 4'd1;
         end
      end

      // restart the blink on entry and on each edit so the field shows
      if (state_d == RUN || btn_mode || edit) begin
         bcnt_d = 8'd0;
         phase_d = 1'b0;
      end else if (blink_tick) begin
         if (bcnt_q + 8'd1 >= BDIV) begin
            bcnt_d = 8'd0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d = bcnt_q + 8'd1;
         end
      end

      blank = (state_d != RUN) && phase_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0_q <= 4'd0;
         s1_q <= 4'd0;
         m0_q <= 4'd0;
         m1_q <= 4'd0;
         h0_q <= 4'd0;
         h1_q <= 4'd0;
         bcnt_q <= 8'd0;
         phase_q <= 1'b0;
         sec0 <= 4'd0;
         sec1 <= 4'd0;
         min0 <= 4'd0;
         min1 <= 4'd0;
         hour0 <= 4'd0;
         hour1 <= 4'd0;
      end else begin
         s0_q <= s0_d;
         s1_q <= s1_d;
         m0_q <= m0_d;
         m1_q <= m1_d;
         h0_q <= h0_d;
         h1_q <= h1_d;
         bcnt_q <= bcnt_d;
         phase_q <= phase_d;
         sec0 <= (blank && state_d == SET_SEC) ? BLK : s0_d;
         sec1 <= (blank && state_d == SET_SEC) ? BLK : s1_d;
         min0 <= (blank && state_d == SET_MIN) ? BLK : m0_d;
         min1 <= (blank && state_d == SET_MIN) ? BLK : m1_d;
         hour0 <= (blank && state_d == SET_HOUR) ? BLK : h0_d;
         hour1 <= (blank && state_d == SET_HOUR) ? BLK : h1_d;
      end
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scoreboard bench for time_set_ctrl.
// Main DUT HOUR_MAX=23 BLINK_DIV=2; second DUT HOUR_MAX=11 BLINK_DIV=1.
module tb_time_set_ctrl;

   typedef logic [3:0] stim_t; // {mode, inc, tick, blink}
   localparam stim_t IDLE = 4'b0000;
   localparam stim_t MODE = 4'b1000;
   localparam stim_t INC  = 4'b0100;
   localparam stim_t TICK = 4'b0010;
   localparam stim_t BLKT = 4'b0001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick_1hz = 1'b0, blink_tick = 1'b0;
   logic btn_mode = 1'b0, btn_inc = 1'b0;
   logic [3:0] sec0, sec1, min0, min1, hour0, hour1;
   logic [1:0] mode;

   logic b_tick = 1'b0, b_blink = 1'b0, b_mode = 1'b0, b_inc = 1'b0;
   logic [3:0] x_s0, x_s1, x_m0, x_m1, x_h0, x_h1;
   logic [1:0] x_mode;

   int checks = 0;
   int errors = 0;

   logic [25:0] sb[$];

   // reference model state
   int mh, mm, ms, mst, mbc;
   bit mph;

   always #5 clk = ~clk;

   time_set_ctrl #(.HOUR_MAX(23), .BLINK_DIV(2)) u_dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .blink_tick(blink_tick),
      .btn_mode(btn_mode), .btn_inc(btn_inc),
      .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1),
      .hour0(hour0), .hour1(hour1), .mode(mode)
   );

   time_set_ctrl #(.HOUR_MAX(11), .BLINK_DIV(1)) u_h11 (
      .clk(clk), .rst(rst), .tick_1hz(b_tick), .blink_tick(b_blink),
      .btn_mode(b_mode), .btn_inc(b_inc),
      .sec0(x_s0), .sec1(x_s1), .min0(x_m0), .min1(x_m1),
      .hour0(x_h0), .hour1(x_h1), .mode(x_mode)
   );

   function automatic logic [25:0] dut_vec();
      return {mode, hour1, hour0, min1, min0, sec1, sec0};
   endfunction

   function automatic logic [25:0] h11_vec();
      return {x_mode, x_h1, x_h0, x_m1, x_m0, x_s1, x_s0};
   endfunction

   function automatic logic [25:0] model_out();
      logic [7:0] h, m, s;
      h = {4'(mh / 10), 4'(mh % 10)};
      m = {4'(mm / 10), 4'(mm % 10)};
      s = {4'(ms / 10), 4'(ms % 10)};
      if (mph && mst == 1) h = 8'hFF;
      if (mph && mst == 2) m = 8'hFF;
      if (mph && mst == 3) s = 8'hFF;
      return {2'(mst), h, m, s};
   endfunction

   task automatic model_reset();
      mh = 0; mm = 0; ms = 0; mst = 0; mbc = 0; mph = 0;
   endtask

   task automatic model_step(input stim_t c);
      int nst;
      bit ed;
      ed = (mst != 0) && c[2] && !c[3];
      if (mst == 0 && c[1]) begin
         ms++;
         if (ms == 60) begin
            ms = 0; mm++;
            if (mm == 60) begin
               mm = 0;
               mh = (mh == 23) ? 0 : mh + 1;
            end
         end
      end
      if (ed && mst == 1) mh = (mh == 23) ? 0 : mh + 1;
      if (ed && mst == 2) mm = (mm + 1) % 60;
      if (ed && mst == 3) ms = (ms + 1) % 60;
      nst = c[3] ? (mst + 1) % 4 : mst;
      if (nst == 0 || c[3] || ed) begin
         mbc = 0; mph = 0;
      end else if (c[0]) begin
         mbc++;
         if (mbc == 2) begin
            mbc = 0; mph = !mph;
         end
      end
      mst = nst;
   endtask

   // drive one cycle of stimulus; expected result goes to the scoreboard
   task automatic step(input stim_t c);
      @(negedge clk);
      btn_mode = c[3]; btn_inc = c[2]; tick_1hz = c[1]; blink_tick = c[0];
      model_step(c);
      sb.push_back(model_out());
      @(posedge clk);
      #1;
      btn_mode = 0; btn_inc = 0; tick_1hz = 0; blink_tick = 0;
   endtask

   task automatic h11_step(input stim_t c);
      @(negedge clk);
      b_mode = c[3]; b_inc = c[2]; b_tick = c[1]; b_blink = c[0];
      @(posedge clk);
      #1;
      b_mode = 0; b_inc = 0; b_tick = 0; b_blink = 0;
   endtask

   task automatic test_reset();
      logic [25:0] got, exp;
      #2 rst = 1'b0;
      #1;
      checks++;
      if (dut_vec() !== 26'h0) begin
         errors++;
         $display("FAIL reset_async got %h exp %h", dut_vec(), 26'h0);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(IDLE);
         exp = sb.pop_front();
         got = dut_vec();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL reset_idle[%0d] got %h exp %h", i, got, exp);
         end
      end
   endtask

   task automatic test_set_wrap();
      stim_t q[$];
      logic [25:0] got, exp;
      q.push_back(MODE);
      for (int k = 0; k < 23; k++) q.push_back(INC);
      q.push_back(MODE);
      for (int k = 0; k < 59; k++) q.push_back(INC);
      q.push_back(MODE);
      for (int k = 0; k < 59; k++) q.push_back(INC);
      q.push_back(MODE);
      q.push_back(IDLE);
      q.push_back(TICK);
      foreach (q[i]) begin
         step(q[i]);
         exp = sb.pop_front();
         got = dut_vec();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL set_wrap[%0d] got %h exp %h", i, got, exp);
         end
      end
      checks++;
      if (dut_vec() !== 26'h0) begin
         errors++;
         $display("FAIL wrap_235959 got %h exp %h", dut_vec(), 26'h0);
      end
   endtask

   task automatic test_hour_inc();
      stim_t q[$];
      logic [25:0] got, exp;
      q.push_back(MODE);
      for (int k = 0; k < 25; k++) q.push_back(INC);
      q.push_back(TICK);
      q.push_back(TICK);
      q.push_back(INC | TICK);
      q.push_back(TICK);
      foreach (q[i]) begin
         step(q[i]);
         exp = sb.pop_front();
         got = dut_vec();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL hour_inc[%0d] got %h exp %h", i, got, exp);
         end
      end
      // 25 + 1 increments from 00 wrap past 23 to 02
      checks++;
      if ({hour1, hour0, min1, min0, sec1, sec0} !== 24'h020000) begin
         errors++;
         $display("FAIL hour_inc_val got %h exp %h",
                  {hour1, hour0, min1, min0, sec1, sec0}, 24'h020000);
      end
      step(MODE | INC);
      exp = sb.pop_front();
      got = dut_vec();
      checks++;
      if (got !== exp || mode !== 2'b10 || {hour1, hour0} !== 8'h02) begin
         errors++;
         $display("FAIL mode_inc_same got %h exp %h", got, exp);
      end
   endtask

   task automatic test_blink();
      stim_t q[$];
      logic [25:0] got, exp;
      q = {BLKT, BLKT, BLKT, BLKT, BLKT, BLKT};
      foreach (q[i]) begin
         step(q[i]);
         exp = sb.pop_front();
         got = dut_vec();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL blink[%0d] got %h exp %h", i, got, exp);
         end
         checks++;
         if (hour1 === 4'hF || hour0 === 4'hF ||
             sec1 === 4'hF || sec0 === 4'hF) begin
            errors++;
            $display("FAIL blink_other[%0d] got %h exp no F", i, got);
         end
      end
      checks++;
      if ({min1, min0} !== 8'hFF) begin
         errors++;
         $display("FAIL blink_blank got %h exp %h", {min1, min0}, 8'hFF);
      end
      step(INC);
      exp = sb.pop_front();
      got = dut_vec();
      checks++;
      if (got !== exp || {min1, min0} !== 8'h01) begin
         errors++;
         $display("FAIL blink_inc got %h exp %h", got, exp);
      end
      q = {MODE, MODE, TICK};
      foreach (q[i]) begin
         step(q[i]);
         exp = sb.pop_front();
         got = dut_vec();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL blink_exit[%0d] got %h exp %h", i, got, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      stim_t q[$];
      logic [25:0] got, exp;
      q.push_back(MODE);
      for (int k = 0; k < 10; k++) q.push_back(INC);
      q.push_back(MODE);
      for (int k = 0; k < 33; k++) q.push_back(INC);
      q.push_back(MODE);
      for (int k = 0; k < 55; k++) q.push_back(INC);
      q.push_back(MODE);
      foreach (q[i]) begin
         step(q[i]);
         exp = sb.pop_front();
         got = dut_vec();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL preset[%0d] got %h exp %h", i, got, exp);
         end
      end
      checks++;
      if (dut_vec() !== 26'h0_12_34_56) begin
         errors++;
         $display("FAIL preset_val got %h exp %h", dut_vec(), 26'h0_12_34_56);
      end
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (dut_vec() !== 26'h0) begin
         errors++;
         $display("FAIL reset_mid got %h exp %h", dut_vec(), 26'h0);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      q = {IDLE, IDLE, IDLE, TICK};
      foreach (q[i]) begin
         step(q[i]);
         exp = sb.pop_front();
         got = dut_vec();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL reset_rel[%0d] got %h exp %h", i, got, exp);
         end
      end
   endtask

   task automatic test_mode_tick();
      stim_t q[$];
      logic [25:0] got, exp;
      for (int k = 0; k < 8; k++) q.push_back(TICK);
      q.push_back(MODE | TICK);
      foreach (q[i]) begin
         step(q[i]);
         exp = sb.pop_front();
         got = dut_vec();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL mode_tick[%0d] got %h exp %h", i, got, exp);
         end
      end
      checks++;
      if (mode !== 2'b01 || {sec1, sec0} !== 8'h10) begin
         errors++;
         $display("FAIL mode_tick_same got %h exp mode 1 sec 10", dut_vec());
      end
   endtask

   task automatic test_full_cycle();
      stim_t q[$];
      logic [25:0] got, exp;
      q = {BLKT, BLKT, TICK, MODE, BLKT, BLKT, MODE, BLKT, BLKT, MODE,
           TICK, TICK};
      foreach (q[i]) begin
         step(q[i]);
         exp = sb.pop_front();
         got = dut_vec();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL full_cycle[%0d] got %h exp %h", i, got, exp);
         end
      end
      checks++;
      if (dut_vec() !== 26'h0_00_00_12) begin
         errors++;
         $display("FAIL full_cycle_end got %h exp %h",
                  dut_vec(), 26'h0_00_00_12);
      end
   endtask

   task automatic test_random();
      logic [25:0] got, exp;
      stim_t c;
      for (int i = 0; i < 400; i++) begin
         c[3] = ($urandom_range(0, 9) == 0);
         c[2] = ($urandom_range(0, 2) == 0);
         c[1] = ($urandom_range(0, 1) == 0);
         c[0] = ($urandom_range(0, 2) == 0);
         step(c);
         exp = sb.pop_front();
         got = dut_vec();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL random[%0d] got %h exp %h", i, got, exp);
         end
      end
   endtask

   task automatic test_hour_max11();
      h11_step(MODE);
      for (int k = 0; k < 12; k++) h11_step(INC);
      checks++;
      if (h11_vec() !== 26'h1_00_00_00) begin
         errors++;
         $display("FAIL h11_hwrap got %h exp %h", h11_vec(), 26'h1_00_00_00);
      end
      for (int k = 0; k < 11; k++) h11_step(INC);
      h11_step(MODE);
      for (int k = 0; k < 59; k++) h11_step(INC);
      h11_step(MODE);
      for (int k = 0; k < 59; k++) h11_step(INC);
      h11_step(MODE);
      checks++;
      if (h11_vec() !== 26'h0_11_59_59) begin
         errors++;
         $display("FAIL h11_preset got %h exp %h", h11_vec(), 26'h0_11_59_59);
      end
      h11_step(TICK);
      checks++;
      if (h11_vec() !== 26'h0) begin
         errors++;
         $display("FAIL h11_wrap got %h exp %h", h11_vec(), 26'h0);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_set_wrap();
      test_hour_inc();
      test_blink();
      test_reset_mid();
      test_mode_tick();
      test_full_cycle();
      test_random();
      test_hour_max11();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
